cm138_rr_sched: RTL and testbench
=================================

# cm138_rr_sched

Round-robin scheduler that shares a 3-to-8 active-low decoder among eight requesters. It arbitrates the request vector, then drives the decoder's select lines and enable strobes (one active-high enable, two active-low enables). It also produces a registered, active-low one-hot grant vector that matches the decoder output. It sits between the requesting agents and the decoder and guarantees break-before-make between successive grants.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles a single grant may be held; legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en_in`  in  1  global enable; low forces the block idle.
- `req`  in  8  request vector, bit i = requester i, level-sensitive.
- `sel`  out  3  decoder select {c,b,a}, binary index of the granted requester.
- `dec_g1`  out  1  decoder active-high enable (d).
- `dec_g2a_n`  out  1  decoder active-low enable (e).
- `dec_g2b_n`  out  1  decoder active-low enable (f).
- `gnt_n`  out  8  active-low one-hot grant; all ones when nothing is granted.
- `busy`  out  1  high while in GRANT or GAP.

## Operation
- Three states:
  - IDLE: no grant.
  - GRANT: exactly one requester granted.
  - GAP: one dead cycle, all grants deasserted.
- IDLE → GRANT: when `en_in`=1 and `req`≠0.
  - Winner is the first set bit scanning upward from `ptr`, wrapping 7→0.
  - `ptr` resets to 0.
- In GRANT:
  - `cur` holds the winner.
  - `sel`=`cur`, `dec_g1`=1, `dec_g2a_n`=`dec_g2b_n`=0.
  - `gnt_n` = ~(1<<`cur`).
- GRANT → GAP when any of the following holds:
  - `req[cur]` = 0.
  - `hold_cnt` = `MAX_HOLD`-1.
  - `en_in` = 0.
- On leaving GRANT: `ptr` ← (`cur`+1) mod 8 and `hold_cnt` ← 0.
- While staying in GRANT, `hold_cnt` increments.
- In GAP, all outputs are at idle levels. In GAP, `dec_g1`=0, `dec_g2a_n`=`dec_g2b_n`=1, and `sel` holds its last value.
- Leaving GAP:
  - GAP → GRANT directly when `en_in`=1 and `req`≠0, using the new `ptr`.
  - Otherwise GAP → IDLE.
- Fairness:
  - A requester whose grant hits `MAX_HOLD` is re-eligible only after the scan reaches it again.
  - Any continuously requesting agent waits at most 7×(`MAX_HOLD`+1) cycles.
- `en_in` = 0 in IDLE: the block stays IDLE and ignores `req`.
- `req` changes in GAP or IDLE are sampled only on the arbitration edge. Nothing is latched earlier.
- `hold_cnt` is 4 bits wide. Mod-8 arithmetic on `ptr` and `cur` wraps naturally in 3 bits.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values:
  - state = IDLE; `ptr`=0, `cur`=0, `hold_cnt`=0.
  - `sel`=3'b000, `dec_g1`=0, `dec_g2a_n`=1, `dec_g2b_n`=1.
  - `gnt_n`=8'hFF, `busy`=0.
- Latency: a request sampled at edge t in IDLE shows grant outputs after edge t+1. There are zero idle cycles beyond arbitration.
- Release: `req[cur]` falling at edge t deasserts the grant after edge t+1 (GAP). The next grant can appear no earlier than after edge t+2.
- Hold limit: one grant lasts at most `MAX_HOLD` cycles, followed by at least one GAP cycle.
- Break-before-make: two different `gnt_n` bits are never low in the same or in adjacent cycles.
- Reset mid-grant: `rst_n`=0 at edge t drives all outputs to reset values after edge t. Arbitration state is discarded.
- Simultaneous `req[cur]` drop and hold expiry: single transition to GAP; `ptr` advances once.

## Structure
- Shared package `cm138_pkg`:
  - state enum `sched_state_t` {IDLE, GRANT, GAP};
  - `localparam N_REQ=8`, `SEL_W=3`;
  - `function rr_pick(req, ptr)` returning a found flag and an index.
- One natural sub-module, `rr_pick8`: a combinational rotating priority encoder (8-bit request, 3-bit pointer → valid, 3-bit index).
- The FSM, counters and output registers live in the top level.

## Test plan
- Single request: `req`=8'h20 held, `MAX_HOLD`=4.
  - Grant cycles: `sel`=5, `gnt_n`=8'hDF, `dec_g1`=1.
  - Sequence: 4 grant cycles, then GAP with `gnt_n`=8'hFF, then 4 grant cycles again.
- Full rotation: `req`=8'hFF constant from `ptr`=0.
  - Grants go to 0,1,…,7,0, each 4 cycles with a 1-cycle gap.
  - Exactly one `gnt_n` bit is low per grant cycle.
- Early release: grant requester 2, drop `req[2]` after 1 cycle while `req[6]`=1.
  - Sequence: GAP, then `sel`=6, `gnt_n`=8'hBF.
- Wrap priority: `ptr`=7 (after a grant of 6), `req`=8'h09 → grant 0 first, then 3.
- Enable drop: deassert `en_in` during a grant of requester 4.
  - After the next edge: GAP, then IDLE, `busy`=0, `gnt_n`=8'hFF.
  - No further grants while `en_in`=0.
- Reset mid-grant: assert `rst_n`=0 during a grant of requester 3.
  - All outputs at reset values after one edge.
  - After release with `req`=8'h08, the grant is requester 3 again because `ptr` restarts at 0.

Source files
------------

// File: rtl/cm138_pkg.sv
// Shared types and the rotating-priority pick function for the cm138
// round-robin scheduler.
package cm138_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } sched_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scanning from the farthest offset down to offset 0 lets the nearest
    // set bit at or above ptr overwrite any earlier candidate.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority encoder: picks the first requester at or
// after ptr, wrapping 7 -> 0.
module rr_pick8
    import cm138_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(req, ptr);
        valid = pick.found;
        idx   = pick.idx;
    end

endmodule

// File: rtl/cm138_rr_sched.sv
// Round-robin scheduler sharing a 3-to-8 active-low decoder among eight
// requesters, with a mandatory dead cycle between successive grants.
module cm138_rr_sched
    import cm138_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_in,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       dec_g1,
    output logic       dec_g2a_n,
    output logic       dec_g2b_n,
    output logic [7:0] gnt_n,
    output logic       busy
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    sched_state_t     state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;

    logic [2:0]       sel_q, sel_d;
    logic             dec_g1_q, dec_g1_d;
    logic             dec_g2a_n_q, dec_g2a_n_d;
    logic             dec_g2b_n_q, dec_g2b_n_d;
    logic [7:0]       gnt_n_q, gnt_n_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (en_in && pick_valid) begin
                    state_d    = GRANT;
                    cur_d      = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[cur_q] || (hold_cnt_q == HOLD_LAST) || !en_in) begin
                    state_d    = GAP;
                    ptr_d      = cur_q + 3'd1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (en_in && pick_valid) begin
                    state_d    = GRANT;
                    cur_d      = pick_idx;
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoder controls are a registered image of the current state, so the
    // dead GAP cycle reaches the pins as a full cycle with no glitch path.
    always_comb begin
        sel_d       = sel_q;
        dec_g1_d    = 1'b0;
        dec_g2a_n_d = 1'b1;
        dec_g2b_n_d = 1'b1;
        gnt_n_d     = 8'hFF;
        busy_d      = 1'b0;
        case (state_q)
            GRANT: begin
                sel_d       = cur_q;
                dec_g1_d    = 1'b1;
                dec_g2a_n_d = 1'b0;
                dec_g2b_n_d = 1'b0;
                gnt_n_d     = ~(8'd1 << cur_q);
                busy_d      = 1'b1;
            end
            GAP:     busy_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cur_q       <= '0;
            hold_cnt_q  <= '0;
            sel_q       <= 3'b000;
            dec_g1_q    <= 1'b0;
            dec_g2a_n_q <= 1'b1;
            dec_g2b_n_q <= 1'b1;
            gnt_n_q     <= 8'hFF;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            hold_cnt_q  <= hold_cnt_d;
            sel_q       <= sel_d;
            dec_g1_q    <= dec_g1_d;
            dec_g2a_n_q <= dec_g2a_n_d;
            dec_g2b_n_q <= dec_g2b_n_d;
            gnt_n_q     <= gnt_n_d;
            busy_q      <= busy_d;
        end
    end

    assign sel       = sel_q;
    assign dec_g1    = dec_g1_q;
    assign dec_g2a_n = dec_g2a_n_q;
    assign dec_g2b_n = dec_g2b_n_q;
    assign gnt_n     = gnt_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cm138_rr_sched.sv
// Directed testbench for cm138_rr_sched with MAX_HOLD = 4; outputs sampled
// 1 time unit after each rising edge.
module tb_cm138_rr_sched;

    logic       clk;
    logic       rst_n;
    logic       en_in;
    logic [7:0] req;
    logic [2:0] sel;
    logic       dec_g1;
    logic       dec_g2a_n;
    logic       dec_g2b_n;
    logic [7:0] gnt_n;
    logic       busy;

    int checks;
    int errors;

    cm138_rr_sched #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_in     (en_in),
        .req       (req),
        .sel       (sel),
        .dec_g1    (dec_g1),
        .dec_g2a_n (dec_g2a_n),
        .dec_g2b_n (dec_g2b_n),
        .gnt_n     (gnt_n),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_in = 1'b1;
        req   = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_in = 1'b1;
        req   = 8'hFF;
        tick();
        tick();
        checks++;
        if ({sel, dec_g1, dec_g2a_n, dec_g2b_n, gnt_n, busy} !== {3'b000, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got sel=%0d g1=%b g2a_n=%b g2b_n=%b gnt_n=%h busy=%b, expected 0 0 1 1 ff 0",
                     sel, dec_g1, dec_g2a_n, dec_g2b_n, gnt_n, busy);
        end
        rst_n = 1'b1;
        req   = 8'h00;
    endtask

    task automatic test_single_request();
        do_reset();
        req = 8'h20;
        tick();
        checks++;
        if (gnt_n !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_arb_cycle: gnt_n=%h busy=%b, expected ff 0", gnt_n, busy);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                checks++;
                if (gnt_n !== 8'hDF || sel !== 3'd5 || dec_g1 !== 1'b1 || dec_g2a_n !== 1'b0 || dec_g2b_n !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL single_grant p%0d c%0d: gnt_n=%h sel=%0d g1=%b g2a_n=%b g2b_n=%b busy=%b, expected df 5 1 0 0 1",
                             pass, c, gnt_n, sel, dec_g1, dec_g2a_n, dec_g2b_n, busy);
                end
            end
            tick();
            checks++;
            if (gnt_n !== 8'hFF || dec_g1 !== 1'b0 || dec_g2a_n !== 1'b1 || dec_g2b_n !== 1'b1 || sel !== 3'd5 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_gap p%0d: gnt_n=%h g1=%b g2a_n=%b g2b_n=%b sel=%0d busy=%b, expected ff 0 1 1 5 1",
                         pass, gnt_n, dec_g1, dec_g2a_n, dec_g2b_n, sel, busy);
            end
        end
    endtask

    task automatic test_full_rotation();
        logic [7:0] exp_gnt;
        logic [2:0] exp_sel;
        do_reset();
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            exp_sel = 3'(k % 8);
            exp_gnt = ~(8'd1 << exp_sel);
            for (int c = 0; c < 4; c++) begin
                tick();
                checks++;
                if (gnt_n !== exp_gnt || sel !== exp_sel || $countones(~gnt_n) != 1) begin
                    errors++;
                    $display("[TB] FAIL rotation_grant k%0d c%0d: gnt_n=%h sel=%0d, expected %h %0d",
                             k, c, gnt_n, sel, exp_gnt, exp_sel);
                end
            end
            tick();
            checks++;
            if (gnt_n !== 8'hFF || dec_g1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rotation_gap k%0d: gnt_n=%h g1=%b, expected ff 0", k, gnt_n, dec_g1);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 8'h44;
        tick();
        tick();
        checks++;
        if (gnt_n !== 8'hFB || sel !== 3'd2) begin
            errors++;
            $display("[TB] FAIL early_first_grant: gnt_n=%h sel=%0d, expected fb 2", gnt_n, sel);
        end
        req = 8'h40;
        tick();
        checks++;
        if (gnt_n !== 8'hFB) begin
            errors++;
            $display("[TB] FAIL early_grant_tail: gnt_n=%h, expected fb", gnt_n);
        end
        tick();
        checks++;
        if (gnt_n !== 8'hFF || dec_g1 !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL early_gap: gnt_n=%h g1=%b busy=%b, expected ff 0 1", gnt_n, dec_g1, busy);
        end
        tick();
        checks++;
        if (gnt_n !== 8'hBF || sel !== 3'd6) begin
            errors++;
            $display("[TB] FAIL early_next_grant: gnt_n=%h sel=%0d, expected bf 6", gnt_n, sel);
        end
    endtask

    task automatic test_wrap_priority();
        do_reset();
        req = 8'h40;
        tick();
        tick();
        checks++;
        if (gnt_n !== 8'hBF) begin
            errors++;
            $display("[TB] FAIL wrap_setup_grant6: gnt_n=%h, expected bf", gnt_n);
        end
        req = 8'h09;
        tick();
        tick();
        checks++;
        if (gnt_n !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL wrap_gap_after6: gnt_n=%h, expected ff", gnt_n);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (gnt_n !== 8'hFE || sel !== 3'd0) begin
                errors++;
                $display("[TB] FAIL wrap_grant0 c%0d: gnt_n=%h sel=%0d, expected fe 0", c, gnt_n, sel);
            end
        end
        tick();
        checks++;
        if (gnt_n !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL wrap_gap_after0: gnt_n=%h, expected ff", gnt_n);
        end
        tick();
        checks++;
        if (gnt_n !== 8'hF7 || sel !== 3'd3) begin
            errors++;
            $display("[TB] FAIL wrap_grant3: gnt_n=%h sel=%0d, expected f7 3", gnt_n, sel);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        req = 8'h10;
        tick();
        tick();
        checks++;
        if (gnt_n !== 8'hEF || sel !== 3'd4) begin
            errors++;
            $display("[TB] FAIL endrop_grant4: gnt_n=%h sel=%0d, expected ef 4", gnt_n, sel);
        end
        en_in = 1'b0;
        tick();
        tick();
        checks++;
        if (gnt_n !== 8'hFF || busy !== 1'b1 || dec_g1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL endrop_gap: gnt_n=%h busy=%b g1=%b, expected ff 1 0", gnt_n, busy, dec_g1);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (gnt_n !== 8'hFF || busy !== 1'b0 || dec_g1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL endrop_idle c%0d: gnt_n=%h busy=%b g1=%b, expected ff 0 0", c, gnt_n, busy, dec_g1);
            end
        end
        en_in = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h08;
        tick();
        tick();
        checks++;
        if (gnt_n !== 8'hF7 || sel !== 3'd3) begin
            errors++;
            $display("[TB] FAIL rstmid_grant3: gnt_n=%h sel=%0d, expected f7 3", gnt_n, sel);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({sel, dec_g1, dec_g2a_n, dec_g2b_n, gnt_n, busy} !== {3'b000, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got sel=%0d g1=%b g2a_n=%b g2b_n=%b gnt_n=%h busy=%b, expected 0 0 1 1 ff 0",
                     sel, dec_g1, dec_g2a_n, dec_g2b_n, gnt_n, busy);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt_n !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_arb_cycle: gnt_n=%h busy=%b, expected ff 0", gnt_n, busy);
        end
        tick();
        checks++;
        if (gnt_n !== 8'hF7 || sel !== 3'd3 || dec_g1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_regrant3: gnt_n=%h sel=%0d g1=%b, expected f7 3 1", gnt_n, sel, dec_g1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en_in  = 1'b0;
        req    = 8'h00;
        test_reset();
        test_single_request();
        test_full_rotation();
        test_early_release();
        test_wrap_priority();
        test_enable_drop();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
